// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO 8N1 UART transmitter with TX FIFO; macro UART_TX_IRQ_EN adds irq output and CTRL.ie
// Register window: BASE+0 TXDATA, BASE+4 STATUS, BASE+8 CTRL; readdata/hit are combinational.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        txd
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          en;
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [TW-1:0] tick;
    logic [7:0]    shreg;

    logic full, empty, busy, tick_end;
    logic sel_tx, sel_st, sel_ct;
    logic wr_tx, push, over, pop, clr_ovf;

    assign hit    = (adr[31:4] == BASE_ADDR[31:4]) && (adr[3:2] != 2'b11);
    assign sel_tx = hit && (adr[3:2] == 2'd0);
    assign sel_st = hit && (adr[3:2] == 2'd1);
    assign sel_ct = hit && (adr[3:2] == 2'd2);

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != S_IDLE);
    assign tick_end = (tick == TW'(CLKS_PER_BIT - 1));

    // A store to a full FIFO is dropped even if a pop frees a slot this cycle.
    assign wr_tx   = memwrite && sel_tx;
    assign push    = wr_tx && !full;
    assign over    = wr_tx && full;
    assign pop     = (state == S_IDLE) && en && !empty;
    assign clr_ovf = memwrite && sel_st && writedata[4];

    logic unused_bits;
    assign unused_bits = ^{adr[1:0], writedata[31:8]};

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set beats the W1C clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (over)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

`ifdef UART_TX_IRQ_EN
    logic ie;

    always_ff @(posedge clk) begin
        if (reset) begin
            en <= 1'b0;
            ie <= 1'b0;
        end else if (memwrite && sel_ct) begin
            en <= writedata[0];
            ie <= writedata[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= ie && empty && !busy;
    end
`else
    always_ff @(posedge clk) begin
        if (reset)
            en <= 1'b0;
        else if (memwrite && sel_ct)
            en <= writedata[0];
    end
`endif

    // txd is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            txd    <= 1'b1;
            bitcnt <= '0;
            tick   <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg  <= mem[rptr];
                        tick   <= '0;
                        bitcnt <= '0;
                        state  <= S_START;
                        txd    <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick_end) begin
                        tick  <= '0;
                        state <= S_DATA;
                        txd   <= shreg[0];
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_end) begin
                        tick <= '0;
                        if (bitcnt == 3'd7) begin
                            state <= S_STOP;
                            txd   <= 1'b1;
                        end else begin
                            shreg  <= {1'b0, shreg[7:1]};
                            txd    <= shreg[1];
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_end) begin
                        tick  <= '0;
                        state <= S_IDLE;
                        txd   <= 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        if (hit) begin
            case (adr[3:2])
                2'd1: begin
                    readdata[1] = full;
                    readdata[2] = empty;
                    readdata[3] = busy;
                    readdata[4] = ovf;
`ifdef UART_TX_IRQ_EN
                    readdata[5] = irq;
`endif
                end
                2'd2: begin
                    readdata[0] = en;
`ifdef UART_TX_IRQ_EN
                    readdata[1] = ie;
`endif
                end
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx with a line-level UART receiver model
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hit;
    logic        txd;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .adr(adr),
        .writedata(writedata),
        .memwrite(memwrite),
        .readdata(readdata),
        .hit(hit),
        .txd(txd)
`ifdef UART_TX_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Receiver model: decodes 8N1 frames off txd by mid-bit sampling.
    logic [7:0] rx[$];
    int         starts[$];
    int         cyc = 0;
    int         frame_err = 0;
    bit         in_frame = 0;
    int         mcnt = 0;
    logic [7:0] mbyte = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        #2;
        if (reset === 1'b1) begin
            in_frame = 0;
        end else if (!in_frame) begin
            if (txd === 1'b0) begin
                in_frame = 1;
                mcnt = 0;
                mbyte = 8'h00;
                starts.push_back(cyc);
            end
        end else begin
            mcnt++;
            if (mcnt >= CPB + CPB / 2 && mcnt < 9 * CPB && (mcnt - CPB / 2) % CPB == 0)
                mbyte[(mcnt - CPB / 2) / CPB - 1] = txd;
            if (mcnt == 9 * CPB + CPB / 2) begin
                if (txd !== 1'b1) frame_err++;
                rx.push_back(mbyte);
                in_frame = 0;
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        adr = a;
        writedata = d;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        adr = BASE + 32'd12;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        adr = a;
        memwrite = 1'b0;
        #1;
        d = readdata;
        h = hit;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (rx.size() < n) begin
            n_bad++;
            $display("FAIL wait_rx: got %0d frames, required %0d", rx.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic h;
        reset = 1'b1; memwrite = 1'b0; adr = 32'h0; writedata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b need 1", txd); end
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h4 || h !== 1'b1) begin n_bad++; $display("FAIL reset_status: got %h hit %b need 00000004 hit 1", rd, h); end
        bus_read(BASE + 32'd8, rd, h);
        n_cmp++; if (rd !== 32'h0 || h !== 1'b1) begin n_bad++; $display("FAIL reset_ctrl: got %h hit %b need 0 hit 1", rd, h); end
        bus_read(BASE + 32'd1, rd, h);
        n_cmp++; if (rd !== 32'h0 || h !== 1'b1) begin n_bad++; $display("FAIL read_txdata: got %h hit %b need 0 hit 1", rd, h); end
        bus_read(BASE + 32'd12, rd, h);
        n_cmp++; if (rd !== 32'h0 || h !== 1'b0) begin n_bad++; $display("FAIL read_base12: got %h hit %b need 0 hit 0", rd, h); end
        bus_read(32'h0000_0040, rd, h);
        n_cmp++; if (rd !== 32'h0 || h !== 1'b0) begin n_bad++; $display("FAIL read_0x40: got %h hit %b need 0 hit 0", rd, h); end
        bus_read(BASE + 32'h14, rd, h);
        n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL read_base14: hit %b need 0", h); end
        bus_write(32'h0000_0040, 32'hA5);
        bus_write(BASE + 32'd12, 32'h5A);
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h4) begin n_bad++; $display("FAIL stray_store: status %h need 00000004", rd); end
    endtask

    // Expected line level j half-cycles... j cycles after the push edge: idle, pop edge, 10 bits of CPB each.
    task automatic test_frame(input logic [7:0] b);
        logic e;
        logic eb;
        int k;
        rx.delete();
        bus_write(BASE + 32'd8, 32'h1);
        bus_write(BASE, {24'h0, b});
        adr = BASE + 32'd4;
        for (int j = 0; j <= FRAME + 2; j++) begin
            #1;
            if (j == 0 || j > FRAME) e = 1'b1;
            else begin
                k = (j - 1) / CPB;
                if (k == 0) e = 1'b0;
                else if (k <= 8) e = b[k-1];
                else e = 1'b1;
            end
            eb = (j >= 1 && j <= FRAME);
            n_cmp++; if (txd !== e) begin n_bad++; $display("FAIL frame_txd byte %h cycle %0d: got %b need %b", b, j, txd, e); end
            n_cmp++; if (readdata[3] !== eb) begin n_bad++; $display("FAIL frame_busy byte %h cycle %0d: got %b need %b", b, j, readdata[3], eb); end
            @(negedge clk);
        end
        n_cmp++; if (rx.size() != 1 || rx[0] !== b) begin n_bad++; $display("FAIL frame_rx: got %0d frames first %h need 1 frame %h", rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx, b); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic h;
        bus_write(BASE + 32'd8, 32'h0);
        rx.delete(); starts.delete();
        for (int i = 0; i < 5; i++) bus_write(BASE, 32'h11 + i);
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h12) begin n_bad++; $display("FAIL ovf_status: got %h need 00000012", rd); end
        bus_write(BASE + 32'd4, 32'h10);
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h02) begin n_bad++; $display("FAIL ovf_w1c: got %h need 00000002", rd); end
        bus_write(BASE + 32'd8, 32'h1);
        wait_rx(4, 400);
        repeat (80) @(negedge clk);
        n_cmp++; if (rx.size() != 4) begin n_bad++; $display("FAIL ovf_count: got %0d frames need 4", rx.size()); end
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== 8'(8'h11 + i)) begin n_bad++; $display("FAIL ovf_byte%0d: got %h need %h", i, rx[i], 8'(8'h11 + i)); end
        end
        for (int i = 1; i < starts.size(); i++) begin
            n_cmp++; if (starts[i] - starts[i-1] != FRAME + 1) begin n_bad++; $display("FAIL frame_gap%0d: got %0d cycles need %0d", i, starts[i] - starts[i-1], FRAME + 1); end
        end
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h04) begin n_bad++; $display("FAIL ovf_drain: got %h need 00000004", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic h;
        int lows = 0;
        bus_write(BASE + 32'd8, 32'h0);
        bus_write(BASE, 32'h5A);
        bus_write(BASE, 32'h21);
        bus_write(BASE, 32'h22);
        rx.delete();
        bus_write(BASE + 32'd8, 32'h1);
        repeat (18) @(negedge clk);
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h08 || txd !== 1'b1) begin n_bad++; $display("FAIL mid_bit3: status %h txd %b need 00000008 txd 1", rd, txd); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h04 || txd !== 1'b1) begin n_bad++; $display("FAIL mid_reset: status %h txd %b need 00000004 txd 1", rd, txd); end
        bus_read(BASE + 32'd8, rd, h);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_reset_ctrl: got %h need 0", rd); end
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_cmp++; if (lows != 0 || rx.size() != 0) begin n_bad++; $display("FAIL mid_after: low cycles %0d frames %0d need 0 0", lows, rx.size()); end
    endtask

    task automatic test_en_clear();
        logic [31:0] rd;
        logic h;
        bus_write(BASE + 32'd8, 32'h0);
        bus_write(BASE, 32'h33);
        bus_write(BASE, 32'h44);
        rx.delete();
        bus_write(BASE + 32'd8, 32'h1);
        bus_write(BASE + 32'd8, 32'h0);
        wait_rx(1, 200);
        repeat (2 * FRAME) @(negedge clk);
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rx.size() != 1 || rx[0] !== 8'h33) begin n_bad++; $display("FAIL enclr_first: frames %0d first %h need 1 33", rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx); end
        n_cmp++; if (rd !== 32'h00) begin n_bad++; $display("FAIL enclr_status: got %h need 00000000", rd); end
        bus_write(BASE + 32'd8, 32'h1);
        wait_rx(2, 200);
        repeat (CPB + 4) @(negedge clk);
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rx.size() != 2 || rx[rx.size()-1] !== 8'h44) begin n_bad++; $display("FAIL enclr_second: frames %0d need 2 ending 44", rx.size()); end
        n_cmp++; if (rd !== 32'h04) begin n_bad++; $display("FAIL enclr_done: got %h need 00000004", rd); end
    endtask

    task automatic test_random_bursts();
        logic [31:0] rd;
        logic h;
        logic [7:0] exp[$];
        logic [7:0] b;
        int n;
        logic [31:0] est;
        for (int r = 0; r < 6; r++) begin
            bus_write(BASE + 32'd8, 32'h0);
            rx.delete(); exp.delete();
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                if (exp.size() < DEPTH) exp.push_back(b);
                bus_write(BASE, {$urandom_range(0, 32'hFFFFFF), b});
            end
            est = ((n >= DEPTH) ? 32'h02 : 32'h00) | ((n > DEPTH) ? 32'h10 : 32'h00);
            bus_read(BASE + 32'd4, rd, h);
            n_cmp++; if (rd !== est) begin n_bad++; $display("FAIL rnd%0d_fill: status %h need %h (n=%0d)", r, rd, est, n); end
            bus_write(BASE + 32'd8, 32'h1);
            wait_rx(exp.size(), 120 * DEPTH);
            repeat (CPB + 4) @(negedge clk);
            n_cmp++; if (rx.size() != exp.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d need %0d", r, rx.size(), exp.size()); end
            for (int i = 0; i < exp.size() && i < rx.size(); i++) begin
                n_cmp++; if (rx[i] !== exp[i]) begin n_bad++; $display("FAIL rnd%0d_byte%0d: got %h need %h", r, i, rx[i], exp[i]); end
            end
            est = (n > DEPTH) ? 32'h14 : 32'h04;
            bus_read(BASE + 32'd4, rd, h);
            n_cmp++; if (rd !== est) begin n_bad++; $display("FAIL rnd%0d_end: status %h need %h", r, rd, est); end
            bus_write(BASE + 32'd4, 32'h10);
            bus_read(BASE + 32'd4, rd, h);
            n_cmp++; if (rd !== 32'h04) begin n_bad++; $display("FAIL rnd%0d_clr: status %h need 00000004", r, rd); end
        end
        n_cmp++; if (frame_err != 0) begin n_bad++; $display("FAIL stop_bits: %0d bad stop bits need 0", frame_err); end
    endtask

`ifdef UART_TX_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        logic h;
        bus_write(BASE + 32'd8, 32'h3);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_idle: got %b need 1", irq); end
        bus_write(BASE, 32'h7E);
        for (int j = 1; j <= FRAME + 2; j++) begin
            @(negedge clk);
            n_cmp++; if (irq !== (j == FRAME + 2)) begin n_bad++; $display("FAIL irq_frame cycle %0d: got %b need %b", j, irq, (j == FRAME + 2)); end
        end
        bus_read(BASE + 32'd4, rd, h);
        n_cmp++; if (rd !== 32'h24) begin n_bad++; $display("FAIL irq_status: got %h need 00000024", rd); end
        bus_write(BASE + 32'd8, 32'h1);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_off: got %b need 0", irq); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame(8'hA5);
        for (int i = 0; i < 3; i++) test_frame(8'($urandom_range(0, 255)));
        test_overflow();
        test_reset_mid();
        test_en_clear();
        test_random_bursts();
`ifdef UART_TX_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
